// File: rtl/cus19_crypto_pkg.sv
// rtl/cus19_crypto_pkg.sv - shared types and key schedule for the cus19 ENC/DEC sequencer
// Purpose: sequencer state enum, op encodings, round rotation amount, key schedule.
// Ports: none (package).
// Optional build macro: CUS19_CRYPTO_CNT_EN (consumed by cus19_crypto_seq).
package cus19_crypto_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_A,
    RD_B,
    KEY,
    ROUND,
    WR,
    DONE
  } state_t;

  localparam logic OP_ENC   = 1'b1;
  localparam logic OP_DEC   = 1'b0;
  localparam int   ROT_AMT  = 3;
  localparam int   CIPHER_W = 8;

  // k_r = rotl(key, r) ^ r; the rotate is taken mod 8 so r up to 14 is legal.
  function automatic logic [CIPHER_W-1:0] key_sched(input logic [CIPHER_W-1:0] key,
                                                    input logic [3:0]          r);
    logic [2*CIPHER_W-1:0] dbl;
    dbl = {key, key} << r[2:0];
    return dbl[2*CIPHER_W-1:CIPHER_W] ^ {4'b0000, r};
  endfunction

endpackage

// File: rtl/cus19_crypto_round.sv
// rtl/cus19_crypto_round.sv - combinational single round of the 8-bit cus19 cipher
// Purpose: next_data = round(data, k_r, op) with k_r from the package key schedule.
// Ports:
//   data      in   current state byte
//   key       in   raw key byte
//   r         in   round index
//   op        in   1=ENC, 0=DEC
//   next_data out  state byte after this round
module cus19_crypto_round
  import cus19_crypto_pkg::*;
(
  input  logic [CIPHER_W-1:0] data,
  input  logic [CIPHER_W-1:0] key,
  input  logic [3:0]          r,
  input  logic                op,
  output logic [CIPHER_W-1:0] next_data
);

  logic [CIPHER_W-1:0] k_r;
  logic [CIPHER_W-1:0] mix;
  logic [CIPHER_W-1:0] rot;

  always_comb begin
    k_r = key_sched(key, r);
    if (op == OP_ENC) begin
      mix       = data ^ k_r;
      rot       = {mix[CIPHER_W-1-ROT_AMT:0], mix[CIPHER_W-1:CIPHER_W-ROT_AMT]};
      next_data = rot + k_r;
    end else begin
      // Exact inverse of the ENC step: undo the add, the rotate, then the xor.
      mix       = data - k_r;
      rot       = {mix[ROT_AMT-1:0], mix[CIPHER_W-1:ROT_AMT]};
      next_data = rot ^ k_r;
    end
  end

endmodule

// File: rtl/cus19_crypto_seq.sv
// rtl/cus19_crypto_seq.sv - ENC/DEC instruction sequencer sharing the data-memory port
// Purpose: read data and key from memory, run NUM_ROUNDS cipher rounds, write back.
// Ports:
//   cus19_clk_in / cus19_rst_in        clock, synchronous active-low reset
//   cmd_valid_in / cmd_ready_out       command handshake (ready only in IDLE)
//   cmd_op_in, cmd_addr_a_in/_b_in     op and data/key addresses
//   stall_out                          pipeline stall while busy
//   mem_req_out / mem_gnt_in           arbitrated memory request/grant
//   mem_we_out, mem_addr_out,
//   mem_wdata_out, mem_rdata_in        memory transfer (rdata the cycle after read grant)
//   done_out, result_out               completion pulse and last result
//   op_count_out                       completed-op count, only with CUS19_CRYPTO_CNT_EN
module cus19_crypto_seq
  import cus19_crypto_pkg::*;
#(
  parameter int Data_Width = 8,
  parameter int Addr_Width = 8,
  parameter int NUM_ROUNDS = 4
) (
  input  logic                  cus19_clk_in,
  input  logic                  cus19_rst_in,
  input  logic                  cmd_valid_in,
  output logic                  cmd_ready_out,
  input  logic                  cmd_op_in,
  input  logic [Addr_Width-1:0] cmd_addr_a_in,
  input  logic [Addr_Width-1:0] cmd_addr_b_in,
  output logic                  stall_out,
  output logic                  mem_req_out,
  input  logic                  mem_gnt_in,
  output logic                  mem_we_out,
  output logic [Addr_Width-1:0] mem_addr_out,
  output logic [Data_Width-1:0] mem_wdata_out,
  input  logic [Data_Width-1:0] mem_rdata_in,
  output logic                  done_out,
  output logic [Data_Width-1:0] result_out
`ifdef CUS19_CRYPTO_CNT_EN
  ,
  output logic [15:0]           op_count_out
`endif
);

  localparam logic [3:0] LAST_R = 4'(NUM_ROUNDS - 1);

  state_t                state, state_nxt;
  logic                  op_q;
  logic [Addr_Width-1:0] addr_a_q, addr_b_q;
  logic [Data_Width-1:0] data_q, key_q, result_q, round_out;
  logic [3:0]            rnd_q;
  logic                  b_first_q;
  logic                  last_round;

  cus19_crypto_round u_round (
    .data      (data_q),
    .key       (key_q),
    .r         (rnd_q),
    .op        (op_q),
    .next_data (round_out)
  );

  // ENC counts up to NUM_ROUNDS-1, DEC counts down to 0.
  assign last_round = (op_q == OP_ENC) ? (rnd_q == LAST_R) : (rnd_q == 4'd0);

  always_ff @(posedge cus19_clk_in) begin
    if (!cus19_rst_in) begin
      state     <= IDLE;
      op_q      <= OP_DEC;
      addr_a_q  <= '0;
      addr_b_q  <= '0;
      data_q    <= '0;
      key_q     <= '0;
      rnd_q     <= '0;
      b_first_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (cmd_valid_in) begin
            op_q     <= cmd_op_in;
            addr_a_q <= cmd_addr_a_in;
            addr_b_q <= cmd_addr_b_in;
          end
        end
        RD_A: begin
          if (mem_gnt_in) b_first_q <= 1'b1;
        end
        RD_B: begin
          // Read data is only valid the cycle after the RD_A grant, so later
          // waiting cycles must not overwrite it.
          if (b_first_q) data_q <= mem_rdata_in;
          b_first_q <= 1'b0;
        end
        KEY: begin
          key_q <= mem_rdata_in;
          rnd_q <= (op_q == OP_ENC) ? 4'd0 : LAST_R;
        end
        ROUND: begin
          data_q <= round_out;
          rnd_q  <= (op_q == OP_ENC) ? rnd_q + 4'd1 : rnd_q - 4'd1;
        end
        DONE: begin
          result_q <= data_q;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt     = state;
    cmd_ready_out = 1'b0;
    mem_req_out   = 1'b0;
    mem_we_out    = 1'b0;
    mem_addr_out  = '0;
    mem_wdata_out = '0;
    done_out      = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready_out = 1'b1;
        if (cmd_valid_in) state_nxt = RD_A;
      end
      RD_A: begin
        mem_req_out  = 1'b1;
        mem_addr_out = addr_a_q;
        if (mem_gnt_in) state_nxt = RD_B;
      end
      RD_B: begin
        mem_req_out  = 1'b1;
        mem_addr_out = addr_b_q;
        if (mem_gnt_in) state_nxt = KEY;
      end
      KEY: begin
        state_nxt = ROUND;
      end
      ROUND: begin
        if (last_round) state_nxt = WR;
      end
      WR: begin
        mem_req_out   = 1'b1;
        mem_we_out    = 1'b1;
        mem_addr_out  = addr_a_q;
        mem_wdata_out = data_q;
        if (mem_gnt_in) state_nxt = DONE;
      end
      DONE: begin
        done_out  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign stall_out  = (state != IDLE);
  // The new result is visible in the DONE cycle itself, then held in result_q.
  assign result_out = (state == DONE) ? data_q : result_q;

`ifdef CUS19_CRYPTO_CNT_EN
  always_ff @(posedge cus19_clk_in) begin
    if (!cus19_rst_in) begin
      op_count_out <= '0;
    end else if (state == DONE) begin
      op_count_out <= op_count_out + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cus19_crypto_seq.sv
// tb/tb_cus19_crypto_seq.sv - directed self-checking bench for cus19_crypto_seq
`timescale 1ns/1ps
module tb_cus19_crypto_seq;

  logic       clk = 1'b0;
  logic       rstn;
  logic       valid, ready, op;
  logic [7:0] a, b;
  logic       stall, req, gnt, we, done;
  logic [7:0] addr, wdata, rdata, result;
`ifdef CUS19_CRYPTO_CNT_EN
  logic [15:0] op_count;
`endif

  int checks = 0;
  int failures = 0;

  logic [7:0] mem [0:255];
  logic [7:0] rd_q = 8'h00;
  logic       rd_pend = 1'b0;
  logic       poke_en = 1'b0;
  logic [7:0] poke_addr = 8'h00;
  logic [7:0] poke_data = 8'h00;
  int         writes = 0;
  int         done_pulses = 0;

  always #5 clk = ~clk;

  cus19_crypto_seq dut (
    .cus19_clk_in  (clk),
    .cus19_rst_in  (rstn),
    .cmd_valid_in  (valid),
    .cmd_ready_out (ready),
    .cmd_op_in     (op),
    .cmd_addr_a_in (a),
    .cmd_addr_b_in (b),
    .stall_out     (stall),
    .mem_req_out   (req),
    .mem_gnt_in    (gnt),
    .mem_we_out    (we),
    .mem_addr_out  (addr),
    .mem_wdata_out (wdata),
    .mem_rdata_in  (rdata),
    .done_out      (done),
    .result_out    (result)
`ifdef CUS19_CRYPTO_CNT_EN
    ,
    .op_count_out  (op_count)
`endif
  );

  // Memory model: read data is valid only the cycle after a read grant,
  // otherwise a junk pattern is presented.
  always @(posedge clk) begin
    rd_pend <= 1'b0;
    if (poke_en) begin
      mem[poke_addr] <= poke_data;
    end else if (req && gnt) begin
      if (we) begin
        mem[addr] <= wdata;
        writes    <= writes + 1;
      end else begin
        rd_q    <= mem[addr];
        rd_pend <= 1'b1;
      end
    end
  end
  assign rdata = rd_pend ? rd_q : 8'h5C;

  always @(posedge clk) if (done) done_pulses <= done_pulses + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [7:0] pa, input logic [7:0] pd);
    poke_addr = pa;
    poke_data = pd;
    poke_en   = 1'b1;
    tick();
    poke_en   = 1'b0;
  endtask

  // Issue one command and watch until the sequencer is idle again.
  // Sample c=1 is the cycle right after the accepting edge.
  task automatic run_op(input logic o, input logic [7:0] aa, input logic [7:0] bb,
                        output int done_at, output int stall_n, output int done_n);
    valid = 1'b1; op = o; a = aa; b = bb;
    tick();
    valid = 1'b0;
    done_at = 0; stall_n = 0; done_n = 0;
    for (int c = 1; c <= 60; c++) begin
      if (stall) stall_n++;
      if (done) begin done_n++; done_at = c; end
      if (!stall) break;
      tick();
    end
  endtask

  // Four waiting cycles; grant is given on the last one.
  task automatic hold_phase(input string tag, input logic [17:0] exp_bus);
    for (int i = 0; i < 4; i++) begin
      chk(tag, {14'd0, req, we, addr, wdata}, {14'd0, exp_bus});
      if (i == 3) gnt = 1'b1;
      tick();
    end
    gnt = 1'b0;
  endtask

  int d_at, s_n, d_n, w0, p0, busy_ready;

  initial begin
    rstn = 1'b0; valid = 1'b0; op = 1'b0; a = 8'h00; b = 8'h00; gnt = 1'b1;
    repeat (3) tick();

    chk("rst_ready",  ready,  1);
    chk("rst_stall",  stall,  0);
    chk("rst_bus",    {req, we, addr, wdata}, 0);
    chk("rst_done",   done,   0);
    chk("rst_result", result, 0);

    rstn = 1'b1;
    poke(8'd3, 8'h0A);
    poke(8'd5, 8'h05);

    // ENC with gnt tied high
    w0 = writes;
    run_op(1'b1, 8'd3, 8'd5, d_at, s_n, d_n);
    chk("enc_done_cycle", d_at, 9);
    chk("enc_stall_cycles", s_n, 9);
    chk("enc_done_pulses", d_n, 1);
    chk("enc_mem3", mem[3], 8'hAE);
    chk("enc_result", result, 8'hAE);
    chk("enc_writes", writes - w0, 1);

    // DEC accepted in the cycle after DONE
    run_op(1'b0, 8'd3, 8'd5, d_at, s_n, d_n);
    chk("dec_done_cycle", d_at, 9);
    chk("dec_mem3", mem[3], 8'h0A);
    chk("dec_result", result, 8'h0A);

    // ENC with grant withheld three cycles in each memory phase
    p0 = done_pulses;
    valid = 1'b1; op = 1'b1; a = 8'd3; b = 8'd5; gnt = 1'b0;
    tick();
    valid = 1'b0;
    hold_phase("wait_rd_a", {1'b1, 1'b0, 8'h03, 8'h00});
    hold_phase("wait_rd_b", {1'b1, 1'b0, 8'h05, 8'h00});
    chk("wait_no_done", done_pulses - p0, 0);
    repeat (5) tick();
    hold_phase("wait_wr", {1'b1, 1'b1, 8'h03, 8'hAE});
    chk("wait_done_c18", done, 1);
    chk("wait_result", result, 8'hAE);
    tick();
    chk("wait_idle", stall, 0);
    chk("wait_mem3", mem[3], 8'hAE);
    chk("wait_pulses", done_pulses - p0, 1);
    gnt = 1'b1;
`ifdef CUS19_CRYPTO_CNT_EN
    chk("cnt_three", op_count, 3);
`endif

    // Reset while in the r=2 round
    w0 = writes; p0 = done_pulses;
    valid = 1'b1; op = 1'b1; a = 8'd3; b = 8'd5;
    tick();
    valid = 1'b0;
    repeat (5) tick();
    rstn = 1'b0;
    tick();
    chk("mid_rst_stall", stall, 0);
    chk("mid_rst_ready", ready, 1);
    chk("mid_rst_bus", {req, we, addr, wdata}, 0);
    chk("mid_rst_result", result, 0);
`ifdef CUS19_CRYPTO_CNT_EN
    chk("cnt_reset", op_count, 0);
`endif
    rstn = 1'b1;
    repeat (12) tick();
    chk("mid_rst_no_done", done_pulses - p0, 0);
    chk("mid_rst_no_write", writes - w0, 0);
    chk("mid_rst_mem3", mem[3], 8'hAE);

    // a == b, cmd_valid held high through the operation
    poke(8'd7, 8'h00);
    p0 = done_pulses; busy_ready = 0;
    valid = 1'b1; op = 1'b1; a = 8'd7; b = 8'd7;
    tick();
    for (int c = 1; c <= 9; c++) begin
      if (ready) busy_ready++;
      tick();
    end
    chk("hold_busy_ready", busy_ready, 0);
    chk("hold_idle_ready", ready, 1);
    valid = 1'b0;
    chk("hold_mem7", mem[7], 8'hCD);
    chk("hold_result", result, 8'hCD);
    chk("hold_pulses", done_pulses - p0, 1);
    tick();
    chk("hold_not_requeued", stall, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cus19_crypto_seq.md
Name: cus19_crypto_seq

Overview:
Sequencer for the ENC/DEC S-type instructions of the cus19 core.
- Accepts a decoded command from execute: op, plus the two data-memory addresses held in rs_a and rs_b.
- Fetches plaintext/ciphertext from data_mem[addr_a] and the key from data_mem[addr_b].
- Runs NUM_ROUNDS of the 8-bit round cipher, writes the result back to data_mem[addr_a], and stalls the pipeline while busy.
- Shares the single data-memory port with load/store through a req/gnt arbiter.

Parameters:
Data_Width, 8, data and key width (round function defined for 8 only)
Addr_Width, 8, data-memory address width
NUM_ROUNDS, 4, cipher rounds (1..15)

Ports:
cus19_clk_in  input  1  clock; all logic on rising edge
cus19_rst_in  input  1  synchronous, active-low reset
cmd_valid_in  input  1  command present from execute
cmd_ready_out  output  1  high only in IDLE
cmd_op_in  input  1  1=ENC, 0=DEC (instr bit 3)
cmd_addr_a_in  input  Addr_Width  data/result address (reg_file[rs_a])
cmd_addr_b_in  input  Addr_Width  key address (reg_file[rs_b])
stall_out  output  1  high whenever state != IDLE
mem_req_out  output  1  memory port request
mem_gnt_in  input  1  arbiter grant; transfer occurs in the cycle req&gnt
mem_we_out  output  1  1=write
mem_addr_out  output  Addr_Width  address
mem_wdata_out  output  Data_Width  write data
mem_rdata_in  input  Data_Width  read data, valid the cycle after read grant
done_out  output  1  one-cycle pulse on completion
result_out  output  Data_Width  last result, held until next completion

Behaviour:
Reset (cus19_rst_in=0 at an edge):
- state=IDLE; all outputs 0 except cmd_ready_out=1.
- Internal data/key/round registers are cleared.

States and transitions:
- IDLE: on cmd_valid&cmd_ready, latch op and both addresses -> RD_A.
- RD_A: req=1, we=0, addr=addr_a; hold until gnt, then -> RD_B.
- RD_B: capture mem_rdata into data on the first cycle only. req=1, addr=addr_b; hold until gnt, then -> KEY.
- KEY: capture mem_rdata into key; round counter r = 0 for ENC, NUM_ROUNDS-1 for DEC. -> ROUND.
- ROUND: data <= round(data, k_r, op) each cycle; r increments for ENC, decrements for DEC. After NUM_ROUNDS cycles -> WR.
- WR: req=1, we=1, addr=addr_a, wdata=data; hold until gnt, then -> DONE.
- DONE: done_out=1 and result_out<=data (visible that cycle) -> IDLE.

Round function (all arithmetic mod 256):
- k_r = rotl(key, r) ^ r.
- ENC: x = rotl3(x ^ k_r) + k_r.
- DEC: x = rotr3(x - k_r) ^ k_r.

Latency: command accepted at edge T with no contention gives done_out high in cycle T+5+NUM_ROUNDS (9 at the default). Each cycle gnt is withheld adds one cycle.

Boundary conditions:
- mem_req_out, mem_addr_out, mem_we_out and mem_wdata_out are stable while waiting for gnt.
- gnt is ignored when req=0.
- addr_a==addr_b is legal: the key equals the plaintext, and the write overwrites both.
- cmd_valid while busy is ignored (ready=0); the command is not queued.
- Reset mid-operation: IDLE next cycle, req drops, no write is issued, done_out stays 0, result_out clears.
- A new command can be accepted in the cycle after DONE.

Optional Feature:
CUS19_CRYPTO_CNT_EN
- Defined: adds output op_count_out [15:0], a count of completed operations that increments in the DONE cycle, wraps 0xFFFF->0, and resets to 0.
- Undefined: no port, no counter logic.

Decomposition:
Package cus19_crypto_pkg holds:
- the state enum (IDLE, RD_A, RD_B, KEY, ROUND, WR, DONE)
- OP_ENC=1 and OP_DEC=0
- the rotation amount 3
- the key-schedule function.

Sub-module cus19_crypto_round:
- combinational; inputs data, key, r, op; output next data.
- Reused by the bench model.

Test Plan:
1. Set mem[3]=0x0A, mem[5]=0x05; issue ENC a=3 b=5 with gnt tied 1 -> mem[3]=0xAE, result_out=0xAE, done_out in cycle T+9, stall high for 9 cycles.
2. After scenario 1, issue DEC a=3 b=5 -> mem[3]=0x0A, result_out=0x0A.
3. Repeat scenario 1 with gnt low for 3 cycles during each of RD_A, RD_B and WR -> same 0xAE, done at T+18, req/addr/we/wdata stable while waiting.
4. Pulse reset during ROUND round 2 -> IDLE next cycle, no write strobe, mem[3] unchanged, done never pulses.
5. Hold cmd_valid high through an operation -> exactly one acceptance per IDLE cycle, ready=0 while busy. With a==b==7 and mem[7]=0x00, ENC completes and writes the computed value to mem[7].
6. With CUS19_CRYPTO_CNT_EN, run 3 operations -> op_count_out=3; after reset -> 0.
